fifo_rd_unpacker: RTL and testbench



---
 rtl/fifo_rd_unpacker.sv | 134 +++++++++++++
 tb/tb_fifo_rd_unpacker.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_unpacker.sv
// Pops a programmed number of wide words from a registered-read FIFO and streams them out as
// narrow valid/ready beats. Define FIFO_RD_UNPACK_MSB_FIRST_EN to emit the top slice first.
module fifo_rd_unpacker #(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_words,
    output logic                 busy,
    output logic                 done,
    output logic                 fifo_read_req,
    input  logic                 fifo_read_ready,
    input  logic [IN_WIDTH-1:0]  fifo_read_data,
    output logic                 m_data_valid,
    input  logic                 m_data_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_data_last
);

    localparam int unsigned RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_t;

    state_t               r_state, w_state_next;
    logic [CNT_WIDTH-1:0] r_num_words;
    logic [CNT_WIDTH-1:0] r_words_req;
    logic [CNT_WIDTH-1:0] r_words_out;
    logic                 r_inflight;
    logic [IN_WIDTH-1:0]  r_buf [2];
    logic                 r_wr_ptr, r_rd_ptr;
    logic [1:0]           r_buf_count;
    logic [BEAT_W-1:0]    r_beat;

    logic                 w_handshake;
    logic                 w_word_done;
    logic                 w_last_word;
    logic [2:0]           w_occ;
    logic [BEAT_W-1:0]    w_slice;
    logic [IN_WIDTH-1:0]  w_head;

    assign w_handshake  = m_data_valid && m_data_ready;
    assign w_word_done  = w_handshake && (r_beat == LAST_BEAT);
    assign w_last_word  = (r_words_out == r_num_words - CNT_WIDTH'(1));
    assign m_data_valid = (r_buf_count != 2'd0);
    assign m_data_last  = m_data_valid && (r_beat == LAST_BEAT) && w_last_word;
    assign busy         = (r_state != StIdle);
    assign done         = (r_state == StDone);

    // A word freed this cycle releases its slot, so RATIO=1 can pop every cycle without bubbles.
    assign w_occ = {1'b0, r_buf_count} + {2'b00, r_inflight} - {2'b00, w_word_done};

    assign fifo_read_req = (r_state == StActive) && fifo_read_ready &&
                           (r_words_req < r_num_words) && (w_occ < 3'd2);

`ifdef FIFO_RD_UNPACK_MSB_FIRST_EN
    assign w_slice = LAST_BEAT - r_beat;
`else
    assign w_slice = r_beat;
`endif

    assign w_head = r_buf[r_rd_ptr];
    assign m_data = w_head[w_slice*OUT_WIDTH +: OUT_WIDTH];

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = (num_words == '0) ? StDone : StActive;
                end
            end
            StActive: begin
                if (w_handshake && m_data_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_num_words <= '0;
            r_words_req <= '0;
            r_words_out <= '0;
            r_inflight  <= 1'b0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_buf_count <= 2'd0;
            r_beat      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= fifo_read_req;

            if (r_state == StIdle && start) begin
                r_num_words <= num_words;
                r_words_req <= '0;
                r_words_out <= '0;
                r_beat      <= '0;
            end

            if (fifo_read_req) begin
                r_words_req <= r_words_req + CNT_WIDTH'(1);
            end

            // Registered FIFO read data is valid the cycle after the pop.
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= fifo_read_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end

            if (w_handshake) begin
                r_beat <= w_word_done ? '0 : r_beat + BEAT_W'(1);
            end

            if (w_word_done) begin
                r_rd_ptr    <= ~r_rd_ptr;
                r_words_out <= r_words_out + CNT_WIDTH'(1);
            end

            r_buf_count <= r_buf_count + {1'b0, r_inflight} - {1'b0, w_word_done};
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Directed bench: a RATIO=4 unpacker and a RATIO=1 unpacker, each fed by a small FIFO model.
module tb_fifo_rd_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- DUT A: 64 -> 16 ----------------
    logic        a_start = 1'b0;
    logic [15:0] a_num = '0;
    logic        a_busy, a_done, a_req, a_valid, a_last;
    logic        a_mready = 1'b1;
    logic [15:0] a_mdata;
    logic [63:0] a_rdata = '0;
    logic        a_frdy;
    logic [63:0] a_mem [32];
    int          a_wp = 0;
    int          a_rp = 0;

    assign a_frdy = (a_wp != a_rp);
    always @(posedge clk) begin
        if (a_req && a_frdy) begin
            a_rdata <= a_mem[a_rp % 32];
            a_rp    <= a_rp + 1;
        end
    end

    fifo_rd_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(16), .CNT_WIDTH(16)) u_dut_a (
        .clk             (clk),
        .reset           (reset),
        .start           (a_start),
        .num_words       (a_num),
        .busy            (a_busy),
        .done            (a_done),
        .fifo_read_req   (a_req),
        .fifo_read_ready (a_frdy),
        .fifo_read_data  (a_rdata),
        .m_data_valid    (a_valid),
        .m_data_ready    (a_mready),
        .m_data          (a_mdata),
        .m_data_last     (a_last)
    );

    // ---------------- DUT B: 64 -> 64 ----------------
    logic        b_start = 1'b0;
    logic [15:0] b_num = '0;
    logic        b_busy, b_done, b_req, b_valid, b_last;
    logic        b_mready = 1'b1;
    logic [63:0] b_mdata;
    logic [63:0] b_rdata = '0;
    logic        b_frdy;
    logic [63:0] b_mem [32];
    int          b_wp = 0;
    int          b_rp = 0;

    assign b_frdy = (b_wp != b_rp);
    always @(posedge clk) begin
        if (b_req && b_frdy) begin
            b_rdata <= b_mem[b_rp % 32];
            b_rp    <= b_rp + 1;
        end
    end

    fifo_rd_unpacker #(.IN_WIDTH(64), .OUT_WIDTH(64), .CNT_WIDTH(16)) u_dut_b (
        .clk             (clk),
        .reset           (reset),
        .start           (b_start),
        .num_words       (b_num),
        .busy            (b_busy),
        .done            (b_done),
        .fifo_read_req   (b_req),
        .fifo_read_ready (b_frdy),
        .fifo_read_data  (b_rdata),
        .m_data_valid    (b_valid),
        .m_data_ready    (b_mready),
        .m_data          (b_mdata),
        .m_data_last     (b_last)
    );

    // ---------------- Monitors (sample on falling edge) ----------------
    logic [15:0] a_ld [$];
    bit          a_ll [$];
    int          a_lc [$];
    int a_pops, a_req_viol, a_done_n, a_done_cyc, a_busy_n, a_valid_n, a_stab_viol, a_max_out;
    bit          a_stall;
    logic [15:0] a_stall_data;
    logic        a_stall_last;

    logic [63:0] b_ld [$];
    bit          b_ll [$];
    int          b_lc [$];
    int b_pops, b_req_n, b_req_viol, b_done_n;

    initial begin
        forever begin
            @(negedge clk);
            if (a_valid && a_mready) begin
                a_ld.push_back(a_mdata);
                a_ll.push_back(a_last);
                a_lc.push_back(cyc);
            end
            if (a_req && a_frdy)  a_pops++;
            if (a_req && !a_frdy) a_req_viol++;
            if (a_done) begin
                a_done_n++;
                a_done_cyc = cyc;
            end
            if (a_busy)  a_busy_n++;
            if (a_valid) a_valid_n++;
            if (a_stall && (!a_valid || a_mdata !== a_stall_data || a_last !== a_stall_last))
                a_stab_viol++;
            a_stall      = a_valid && !a_mready;
            a_stall_data = a_mdata;
            a_stall_last = a_last;
            if (a_pops - a_ld.size() / 4 > a_max_out) a_max_out = a_pops - a_ld.size() / 4;

            if (b_valid && b_mready) begin
                b_ld.push_back(b_mdata);
                b_ll.push_back(b_last);
                b_lc.push_back(cyc);
            end
            if (b_req && b_frdy)  b_pops++;
            if (b_req)            b_req_n++;
            if (b_req && !b_frdy) b_req_viol++;
            if (b_done)           b_done_n++;
        end
    end

    // ---------------- Helpers ----------------
    logic [3:0] bp_pat = 4'b1001;  // ready per cycle: 1,0,0,1
    int bp_idx = 0;
    int st_cyc = 0;

    task automatic clear_mon();
        a_ld.delete(); a_ll.delete(); a_lc.delete();
        a_pops = 0; a_req_viol = 0; a_done_n = 0; a_done_cyc = 0; a_busy_n = 0;
        a_valid_n = 0; a_stab_viol = 0; a_max_out = 0; a_stall = 1'b0;
        b_ld.delete(); b_ll.delete(); b_lc.delete();
        b_pops = 0; b_req_n = 0; b_req_viol = 0; b_done_n = 0;
    endtask

    task automatic step(input int n, input bit bp);
        for (int i = 0; i < n; i++) begin
            a_mready = bp ? bp_pat[bp_idx % 4] : 1'b1;
            bp_idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input bit sel_b, input int budget, input bit bp);
        int k = 0;
        while (k < budget && (sel_b ? b_done_n : a_done_n) == 0) begin
            step(1, bp);
            k++;
        end
        step(2, 1'b0);
    endtask

    task automatic push_a(input logic [63:0] w);
        a_mem[a_wp % 32] = w;
        a_wp++;
    endtask

    task automatic start_a(input logic [15:0] n);
        a_mready = 1'b1;
        a_num    = n;
        a_start  = 1'b1;
        st_cyc   = cyc;
        @(posedge clk);
        #1;
        a_start  = 1'b0;
    endtask

    function automatic int count_last_a();
        int c = 0;
        foreach (a_ll[i]) c += int'(a_ll[i]);
        return c;
    endfunction

    initial begin
        clear_mon();
        step(3, 1'b0);

        // Reset state
        check("rst_a_outs", 64'({a_busy, a_done, a_req, a_valid, a_last}), 64'd0);
        check("rst_b_outs", 64'({b_busy, b_done, b_req, b_valid, b_last}), 64'd0);
        reset = 1'b0;
        step(2, 1'b0);

        // T1: RATIO=4, two words, ready high
        clear_mon();
        push_a(64'h0004_0003_0002_0001);
        push_a(64'h0008_0007_0006_0005);
        start_a(16'd2);
        wait_done(1'b0, 60, 1'b0);
        check("t1_beats", 64'(a_ld.size()), 64'd8);
        for (int i = 0; i < 8; i++) check($sformatf("t1_beat%0d", i), 64'(a_ld[i]), 64'(i + 1));
        check("t1_last_pos", 64'(a_ll[7]), 64'd1);
        check("t1_last_cnt", 64'(count_last_a()), 64'd1);
        check("t1_latency", 64'(a_lc[0] - st_cyc), 64'd3);
        check("t1_back2back", 64'(a_lc[7] - a_lc[0]), 64'd7);
        check("t1_done_cyc", 64'(a_done_cyc - a_lc[7]), 64'd1);
        check("t1_done_n", 64'(a_done_n), 64'd1);
        check("t1_pops", 64'(a_pops), 64'd2);

        // T2: RATIO=1, eight words
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            b_mem[b_wp % 32] = 64'hC0DE_0000_0000_0000 + 64'(i * 17);
            b_wp++;
        end
        b_num   = 16'd8;
        b_start = 1'b1;
        st_cyc  = cyc;
        step(1, 1'b0);
        b_start = 1'b0;
        wait_done(1'b1, 60, 1'b0);
        check("t2_beats", 64'(b_ld.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_beat%0d", i), b_ld[i], 64'hC0DE_0000_0000_0000 + 64'(i * 17));
        check("t2_latency", 64'(b_lc[0] - st_cyc), 64'd3);
        check("t2_back2back", 64'(b_lc[7] - b_lc[0]), 64'd7);
        check("t2_req_cycles", 64'(b_req_n), 64'd8);
        check("t2_last_pos", 64'({b_ll[6], b_ll[7]}), 64'b01);
        check("t2_done_n", 64'(b_done_n), 64'd1);
        check("t2_req_empty", 64'(b_req_viol), 64'd0);

        // T3: backpressure 1,0,0,1
        clear_mon();
        push_a(64'h000C_000B_000A_0009);
        push_a(64'h0010_000F_000E_000D);
        push_a(64'h0014_0013_0012_0011);
        start_a(16'd3);
        bp_idx = 0;
        wait_done(1'b0, 200, 1'b1);
        check("t3_beats", 64'(a_ld.size()), 64'd12);
        for (int i = 0; i < 12; i++) check($sformatf("t3_beat%0d", i), 64'(a_ld[i]), 64'(i + 9));
        check("t3_stable", 64'(a_stab_viol), 64'd0);
        check("t3_max_out", 64'(a_max_out <= 2), 64'd1);
        check("t3_last_pos", 64'(a_ll[11]), 64'd1);
        check("t3_last_cnt", 64'(count_last_a()), 64'd1);
        check("t3_done_n", 64'(a_done_n), 64'd1);

        // T4: FIFO runs empty after the first of three words
        clear_mon();
        push_a(64'h0018_0017_0016_0015);
        start_a(16'd3);
        step(10, 1'b0);
        check("t4_stall_beats", 64'(a_ld.size()), 64'd4);
        check("t4_stall_pops", 64'(a_pops), 64'd1);
        check("t4_stall_busy", 64'({a_busy, a_done}), 64'b10);
        push_a(64'h001C_001B_001A_0019);
        push_a(64'h0020_001F_001E_001D);
        wait_done(1'b0, 80, 1'b0);
        check("t4_beats", 64'(a_ld.size()), 64'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("t4_beat%0d", i), 64'(a_ld[i]), 64'(i + 16'h15));
        check("t4_pops", 64'(a_pops), 64'd3);
        check("t4_last_pos", 64'(a_ll[11]), 64'd1);
        check("t4_done_n", 64'(a_done_n), 64'd1);
        check("t4_req_empty", 64'(a_req_viol), 64'd0);

        // T5: zero-length transfer, then a start pulse while active
        clear_mon();
        start_a(16'd0);
        step(4, 1'b0);
        check("t5_zero_done", 64'(a_done_n), 64'd1);
        check("t5_zero_busy", 64'(a_busy_n), 64'd1);
        check("t5_zero_valid", 64'(a_valid_n), 64'd0);
        check("t5_zero_pops", 64'(a_pops), 64'd0);
        clear_mon();
        push_a(64'h0024_0023_0022_0021);
        push_a(64'h0028_0027_0026_0025);
        start_a(16'd1);
        step(2, 1'b0);
        a_num   = 16'd2;
        a_start = 1'b1;
        step(1, 1'b0);
        a_start = 1'b0;
        wait_done(1'b0, 60, 1'b0);
        check("t5_beats", 64'(a_ld.size()), 64'd4);
        check("t5_first", 64'(a_ld[0]), 64'h21);
        check("t5_lastbeat", 64'({a_ld[3], 7'd0, a_ll[3]}), {16'h24, 8'h01});
        check("t5_pops", 64'(a_pops), 64'd1);
        check("t5_done_n", 64'(a_done_n), 64'd1);

        // T6: reset after three beats (FIFO still holds 0x0028... from T5)
        clear_mon();
        push_a(64'h002C_002B_002A_0029);
        start_a(16'd2);
        for (int k = 0; k < 40 && a_ld.size() < 3; k++) step(1, 1'b0);
        a_mready = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_beats", 64'(a_ld.size()), 64'd3);
        check("t6_rst_ctrl", 64'({a_busy, a_done, a_req, a_valid, a_last}), 64'd0);
        check("t6_rst_data", 64'(a_mdata), 64'd0);
        reset = 1'b0;
        clear_mon();
        step(5, 1'b0);
        check("t6_no_done", 64'(a_done_n), 64'd0);
        check("t6_no_valid", 64'(a_valid_n), 64'd0);
        push_a(64'h0030_002F_002E_002D);
        start_a(16'd1);
        wait_done(1'b0, 60, 1'b0);
        check("t6_beats", 64'(a_ld.size()), 64'd4);
        check("t6_first", 64'(a_ld[0]), 64'h2D);
        check("t6_lastbeat", 64'({a_ld[3], 7'd0, a_ll[3]}), {16'h30, 8'h01});
        check("t6_done_n", 64'(a_done_n), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
